// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction memory loader
package imem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        CHECK,
        DATA,
        DONE,
        ERROR
    } loader_state_t;

    localparam int IMEM_DEPTH     = 64;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    // Word index to byte address, matching the PC-based read side.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [29:0] idx);
        return base + {idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_word_packer.sv
// rtl/imem_word_packer.sv - gathers four little-endian bytes into one 32-bit word
module imem_word_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [LANE_W-1:0] lane;
    logic [23:0]       low_bytes;

    // The lane-3 byte is forwarded straight into the word so no bubble is needed.
    assign word_valid = byte_valid && (lane == LANE_W'(BYTES_PER_WORD - 1));
    assign word       = {byte_data, low_bytes};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane      <= '0;
            low_bytes <= '0;
        end else if (clear) begin
            lane      <= '0;
        end else if (byte_valid) begin
            lane      <= lane + 1'b1;
            low_bytes <= {byte_data, low_bytes[23:8]};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time byte-stream writer for the instruction ROM
module imem_loader
    import imem_pkg::*;
#(
    parameter int          DEPTH     = IMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        start,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    localparam int IDX_W = $clog2(DEPTH + 1);

    loader_state_t     state;
    logic [15:0]       count;
    logic [IDX_W-1:0]  index;
    logic              xfer;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign in_ready = (state == HDR_LO) || (state == HDR_HI) || (state == DATA);
    assign xfer     = in_valid && in_ready;

    imem_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (state == CHECK),
        .byte_valid (xfer && (state == DATA)),
        .byte_data  (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= '0;
            index        <= '0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                IDLE: state <= HDR_LO;
                HDR_LO: begin
                    if (xfer) begin
                        count[7:0] <= in_data;
                        state      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (xfer) begin
                        count[15:8] <= in_data;
                        state       <= CHECK;
                    end
                end
                CHECK: begin
                    if (count == 16'd0) begin
                        state <= DONE;
                    end else if (count > 16'(DEPTH)) begin
                        state <= ERROR;
                    end else begin
                        index <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (word_valid) begin
                        mem_we       <= 1'b1;
                        mem_wdata    <= word;
                        mem_addr     <= word_addr(BASE_ADDR, 30'(index));
                        index        <= index + 1'b1;
                        words_loaded <= words_loaded + 16'd1;
                        // DONE is entered during the final write; done/cpu_hold follow a cycle later.
                        if (16'(index) + 16'd1 == count) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        state        <= HDR_LO;
                        done         <= 1'b0;
                        cpu_hold     <= 1'b1;
                        words_loaded <= '0;
                    end else begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                ERROR: begin
                    if (start) begin
                        state        <= HDR_LO;
                        error        <= 1'b0;
                        cpu_hold     <= 1'b1;
                        words_loaded <= '0;
                    end else begin
                        error    <= 1'b1;
                        cpu_hold <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = 8'h00;
    logic        start = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .start        (start),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_addr [0:511];
    logic [31:0] exp_data [0:511];
    logic [31:0] log_addr [0:511];
    logic [31:0] log_data [0:511];
    int          exp_total = 0;
    int          obs_total = 0;
    int          epoch = 0;
    logic [7:0]  payload [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Observer: every write must match the next expected write; words_loaded tracks writes seen.
    initial begin : compare
        int   seen_epoch;
        int   ld_cnt;
        logic prev_we;
        logic prev_done;
        seen_epoch = 0;
        ld_cnt     = 0;
        prev_we    = 1'b0;
        prev_done  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ld_cnt    = 0;
                prev_we   = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (epoch != seen_epoch) begin
                    seen_epoch = epoch;
                    ld_cnt     = 0;
                end
                if (mem_we) begin
                    if (obs_total < exp_total) begin
                        check("write_addr", mem_addr, exp_addr[obs_total]);
                        check("write_data", mem_wdata, exp_data[obs_total]);
                    end else begin
                        check("unexpected_write", 32'(obs_total), 32'(exp_total - 1));
                    end
                    if (obs_total < 512) begin
                        log_addr[obs_total] = mem_addr;
                        log_data[obs_total] = mem_wdata;
                    end
                    check("done_during_write", 32'(done), 32'd0);
                    check("hold_during_write", 32'(cpu_hold), 32'd1);
                    obs_total++;
                    ld_cnt++;
                end
                check("words_loaded", 32'(words_loaded), 32'(ld_cnt));
                check("hold_vs_done", 32'(cpu_hold), 32'(!done));
                if (done && !prev_done && ld_cnt > 0)
                    check("done_lag", 32'(prev_we), 32'd1);
                prev_we   = mem_we;
                prev_done = done;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    // Reference: each complete group of four delivered bytes becomes one write at BASE+4*k.
    task automatic run_load(input logic [15:0] n, input int nbytes, input int maxgap);
        if (n != 16'd0 && n <= 16'(DEPTH)) begin
            for (int w = 0; w < nbytes / 4; w++) begin
                exp_addr[exp_total] = BASE + 32'(4 * w);
                exp_data[exp_total] = {payload[4*w+3], payload[4*w+2], payload[4*w+1], payload[4*w]};
                exp_total++;
            end
        end
        send_byte(n[7:0], $urandom_range(maxgap, 0));
        send_byte(n[15:8], $urandom_range(maxgap, 0));
        if (n != 16'd0 && n <= 16'(DEPTH)) begin
            for (int i = 0; i < nbytes; i++)
                send_byte(payload[i], $urandom_range(maxgap, 0));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fill_random(input int nbytes);
        payload = {};
        for (int i = 0; i < nbytes; i++) payload.push_back(8'($urandom));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        epoch++;
        @(negedge clk);
        check("start_hold", 32'(cpu_hold), 32'd1);
        check("start_done", 32'(done), 32'd0);
        check("start_words", 32'(words_loaded), 32'd0);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", mem_addr, BASE);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin : main
        int base_idx;
        int n;
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // Two words back to back
        base_idx = obs_total;
        payload = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        run_load(16'd2, 8, 0);
        wait_done();
        check("t1_addr0", log_addr[base_idx], 32'h0000_0000);
        check("t1_data0", log_data[base_idx], 32'h0010_0513);
        check("t1_addr1", log_addr[base_idx+1], 32'h0000_0004);
        check("t1_data1", log_data[base_idx+1], 32'h0020_0593);
        check("t1_words", 32'(words_loaded), 32'd2);
        check("t1_hold", 32'(cpu_hold), 32'd0);

        // Empty image: done two cycles after the high header byte
        do_start();
        run_load(16'd0, 0, 0);
        check("t2_done_e1", 32'(done), 32'd0);
        @(negedge clk);
        check("t2_done_e2", 32'(done), 32'd0);
        @(negedge clk);
        check("t2_done_e3", 32'(done), 32'd1);
        check("t2_hold", 32'(cpu_hold), 32'd0);

        // Oversized header
        do_start();
        base_idx = obs_total;
        run_load(16'd65, 0, 0);
        repeat (4) @(negedge clk);
        check("t3_error", 32'(error), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd1);
        check("t3_ready", 32'(in_ready), 32'd0);
        check("t3_done", 32'(done), 32'd0);
        check("t3_nowrite", 32'(obs_total), 32'(base_idx));
        do_start();
        check("t3_rearm_ready", 32'(in_ready), 32'd1);
        check("t3_rearm_error", 32'(error), 32'd0);

        // One word with random valid gaps
        base_idx = obs_total;
        payload = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(16'd1, 4, 3);
        wait_done();
        check("t4_count", 32'(obs_total - base_idx), 32'd1);
        check("t4_data", log_data[base_idx], 32'hDEAD_BEEF);
        check("t4_addr", log_addr[base_idx], BASE);

        // Reset after 6 of 8 data bytes
        do_start();
        fill_random(8);
        run_load(16'd2, 6, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base_idx = obs_total;
        fill_random(4);
        run_load(16'd1, 4, 1);
        wait_done();
        check("t5_addr", log_addr[base_idx], BASE);
        check("t5_words", 32'(words_loaded), 32'd1);

        // Reload from DONE
        do_start();
        base_idx = obs_total;
        fill_random(4);
        run_load(16'd1, 4, 2);
        wait_done();
        check("t6_addr", log_addr[base_idx], 32'h0000_0000);

        // Random loads including the full-depth boundary
        for (int it = 0; it < 6; it++) begin
            n = (it == 3) ? DEPTH : int'($urandom_range(6, 1));
            do_start();
            base_idx = obs_total;
            fill_random(4 * n);
            run_load(16'(n), 4 * n, int'($urandom_range(2, 0)));
            wait_done();
            check("rnd_words", 32'(words_loaded), 32'(n));
            check("rnd_error", 32'(error), 32'd0);
            check("rnd_last_addr", log_addr[base_idx + n - 1], BASE + 32'(4 * (n - 1)));
        end

        repeat (3) @(negedge clk);
        check("total_writes", 32'(obs_total), 32'(exp_total));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the CPU's word-addressed instruction ROM. It fills the ROM write port that sits beside the combinational read port.
- Accepts a byte stream over a valid/ready handshake. The stream is a 16-bit little-endian word count N followed by 4*N instruction bytes, least significant byte first.
- Assembles each group of four bytes into a 32-bit word and writes it at a word-aligned byte address, matching the PC addressing the read side uses.
- Holds the CPU in reset (cpu_hold) until loading completes.

Parameters:
- DEPTH, 64, number of 32-bit words in the instruction memory.
- BASE_ADDR, 32'h0000_0000, byte address of word 0. Must be a multiple of 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  byte source has data
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a rising clk edge
- in_data  in  8  stream byte
- start  in  1  single-cycle pulse; re-arms a load from DONE or ERROR
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  32  byte address, BASE_ADDR + 4*index
- mem_wdata  out  32  assembled instruction word
- cpu_hold  out  1  keeps the CPU in reset while high
- done  out  1  load completed successfully
- error  out  1  header word count exceeded DEPTH
- words_loaded  out  16  words written since the current load began

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, done=0, error=0, words_loaded=0.
  - Byte counter and word count register cleared.
- in_ready is combinational from state: 1 in HDR_LO, HDR_HI and DATA; 0 in IDLE, CHECK, DONE and ERROR. No byte is ever accepted while rst_n is low.
- Reset mid-load abandons the load. Words already written stay in memory; the loader restarts from IDLE.
- FSM:
  - IDLE -> HDR_LO unconditionally on the first clk after reset release.
  - HDR_LO: on transfer, count[7:0]=in_data; go to HDR_HI.
  - HDR_HI: on transfer, count[15:8]=in_data; go to CHECK.
  - CHECK (one cycle): count==0 -> DONE. count>DEPTH -> ERROR. Otherwise DATA with index=0 and byte lane=0.
  - DATA: each transfer stores in_data into shift register lane (lane 0 = bits 7:0) and increments the lane.
    - On the lane-3 transfer at edge T: mem_wdata = assembled word, mem_addr = BASE_ADDR + 4*index, and mem_we is high for exactly the cycle following edge T.
    - words_loaded and index increment at edge T.
    - in_ready stays high, so back-to-back bytes run at one per cycle with no bubble at word boundaries.
  - After the last word's lane-3 transfer: go to DONE. done=1 and cpu_hold=0 take effect one cycle after the final mem_we cycle, so the CPU never leaves reset before the last write has landed.
  - DONE: done=1, cpu_hold=0; in_ready=0.
  - ERROR: error=1, cpu_hold=1; in_ready=0; no writes.
  - In DONE or ERROR, start -> HDR_LO with done=0, error=0, cpu_hold=1, words_loaded=0.
  - start is ignored in every other state.
- Stalls: in_valid low in any accepting state simply holds state. A partial word is held indefinitely; there is no timeout.
- Arithmetic: index is clog2(DEPTH+1) bits wide. mem_addr = BASE_ADDR + {index,2'b00}, computed in 32 bits. The count check is unsigned 16-bit.
- mem_wdata and mem_addr hold their last value when mem_we=0.

Decomposition:
- Shared package imem_pkg:
  - loader state enum (IDLE, HDR_LO, HDR_HI, CHECK, DATA, DONE, ERROR)
  - IMEM_DEPTH=64
  - WORD_W=32
  - BYTES_PER_WORD=4
- One natural sub-module, imem_word_packer: a 4-lane byte shift register plus lane counter that emits word_valid and the word. The FSM, header handling and addressing stay in imem_loader.

Test Plan:
- Header 02 00, then bytes 13 05 10 00 93 05 20 00 at one per cycle -> two single-cycle mem_we pulses: addr 0x00 data 0x00100513, then addr 0x04 data 0x00200593. words_loaded=2; done=1 and cpu_hold=0 one cycle after the second pulse.
- Header 00 00 -> no mem_we; done=1 two cycles after the HDR_HI transfer.
- Header 41 00 (N=65, DEPTH=64) -> error=1, cpu_hold=1, in_ready=0, no mem_we. A start pulse then returns in_ready=1 and clears error.
- Random in_valid gaps inside one word (bytes EF BE AD DE, N=1) -> exactly one mem_we with data 0xDEADBEEF, addr=BASE_ADDR.
- rst_n pulsed low after 6 of 8 data bytes -> all outputs at reset values immediately. A fresh header-plus-word stream then writes word 0 at BASE_ADDR.
- From DONE, a start pulse followed by a new N=1 stream -> cpu_hold back to 1 in the cycle after start, then rewritten at addr 0x00.
